// File: rtl/limit_state_detector64_water.sv
// Limit state detector for a 64-bit (IEEE-754 double) controller limiter.
// Each evaluation compares the captured controller signal against its
// upper/lower bounds and debounces the at-limit conditions. The combined
// hold flag is the anti-windup freeze request sent to the integrator.

`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

module limit_state_detector64_water #(
    parameter int WIDTH = `EXTENDED_SINGLE,
    parameter int DEB_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sta,
    input  logic             clr,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] upper_limit,
    input  logic [WIDTH-1:0] down_limit,
    output logic             hi_flag,
    output logic             lo_flag,
    output logic             windup_hold,
    output logic             err_sig,
    output logic [15:0]      hit_cnt,
    output logic             busy,
    output logic             done_sig
);

    // Double layout: sign at the top, 11-bit exponent, 52-bit mantissa.
    localparam int         MAN_W   = 52;
    localparam logic [3:0] DEB_MAX = 4'(DEB_N);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        UPD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cap_x;
    logic [WIDTH-1:0] cap_up;
    logic [WIDTH-1:0] cap_dn;
    logic             hi_raw;
    logic             lo_raw;
    logic             inv;
    logic [3:0]       hi_cnt;
    logic [3:0]       lo_cnt;
    logic [3:0]       hi_cnt_next;
    logic [3:0]       lo_cnt_next;
    logic             hi_flag_next;
    logic             lo_flag_next;
    logic             hold_next;

    // NaN: exponent all ones with a nonzero mantissa; infinities are ordered.
    function automatic logic is_nan(input logic [WIDTH-1:0] v);
        return (&v[WIDTH-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Strict a < b on non-NaN doubles; +0 and -0 are treated as equal.
    function automatic logic f_less(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[WIDTH-2:0] == '0);
        b_zero = (b[WIDTH-2:0] == '0);
        if (a_zero && b_zero)
            return 1'b0;
        else if (a[WIDTH-1] != b[WIDTH-1])
            return a[WIDTH-1];
        else if (!a[WIDTH-1])
            return a[WIDTH-2:0] < b[WIDTH-2:0];
        else
            return a[WIDTH-2:0] > b[WIDTH-2:0];
    endfunction

    // Next debounce counts and flags for a valid update, saturating at DEB_N.
    always_comb begin
        hi_cnt_next  = 4'd0;
        lo_cnt_next  = 4'd0;
        if (hi_raw)
            hi_cnt_next = (hi_cnt == DEB_MAX) ? hi_cnt : hi_cnt + 4'd1;
        if (lo_raw)
            lo_cnt_next = (lo_cnt == DEB_MAX) ? lo_cnt : lo_cnt + 4'd1;
        hi_flag_next = (hi_cnt_next == DEB_MAX);
        lo_flag_next = (lo_cnt_next == DEB_MAX);
        hold_next    = hi_flag_next | lo_flag_next;
    end

    // Evaluation sequencer: capture, compare, update; clr on hit_cnt wins last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cap_x       <= '0;
            cap_up      <= '0;
            cap_dn      <= '0;
            hi_raw      <= 1'b0;
            lo_raw      <= 1'b0;
            inv         <= 1'b0;
            hi_cnt      <= 4'd0;
            lo_cnt      <= 4'd0;
            hi_flag     <= 1'b0;
            lo_flag     <= 1'b0;
            windup_hold <= 1'b0;
            err_sig     <= 1'b0;
            hit_cnt     <= 16'd0;
            busy        <= 1'b0;
            done_sig    <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sta) begin
                        cap_x  <= x;
                        cap_up <= upper_limit;
                        cap_dn <= down_limit;
                        busy   <= 1'b1;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    hi_raw <= !f_less(cap_x, cap_up);
                    lo_raw <= !f_less(cap_dn, cap_x);
                    inv    <= is_nan(cap_x) || is_nan(cap_up) || is_nan(cap_dn)
                              || f_less(cap_up, cap_dn);
                    state  <= UPD;
                end
                UPD: begin
                    if (inv) begin
                        err_sig     <= 1'b1;
                        hi_cnt      <= 4'd0;
                        lo_cnt      <= 4'd0;
                        hi_flag     <= 1'b0;
                        lo_flag     <= 1'b0;
                        windup_hold <= 1'b0;
                    end else begin
                        err_sig     <= 1'b0;
                        hi_cnt      <= hi_cnt_next;
                        lo_cnt      <= lo_cnt_next;
                        hi_flag     <= hi_flag_next;
                        lo_flag     <= lo_flag_next;
                        windup_hold <= hold_next;
                        if (hold_next && (hit_cnt != 16'hFFFF))
                            hit_cnt <= hit_cnt + 16'd1;
                    end
                    busy     <= 1'b0;
                    done_sig <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (clr)
                hit_cnt <= 16'd0;
        end
    end

endmodule

// File: tb/tb_limit_state_detector64_water.sv
// Scoreboard bench for limit_state_detector64_water: the stimulus side
// pushes hand-computed results, the monitor pops them on each done_sig.

module tb_limit_state_detector64_water;

    localparam logic [63:0] P_ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] N_ONE   = 64'hBFF0000000000000;
    localparam logic [63:0] P_TWO   = 64'h4000000000000000;
    localparam logic [63:0] P_HALF  = 64'h3FE0000000000000;
    localparam logic [63:0] P_ZERO  = 64'h0000000000000000;
    localparam logic [63:0] N_ZERO  = 64'h8000000000000000;
    localparam logic [63:0] N_THREE = 64'hC008000000000000;
    localparam logic [63:0] N_TWO   = 64'hC000000000000000;
    localparam logic [63:0] N_1P5   = 64'hBFF8000000000000;
    localparam logic [63:0] Q_NAN   = 64'h7FF8000000000000;

    typedef struct packed {
        logic        hi;
        logic        lo;
        logic        wh;
        logic        err;
        logic [15:0] hit;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sta;
    logic        clr;
    logic [63:0] x;
    logic [63:0] upper_limit;
    logic [63:0] down_limit;
    logic        hi_flag;
    logic        lo_flag;
    logic        windup_hold;
    logic        err_sig;
    logic [15:0] hit_cnt;
    logic        busy;
    logic        done_sig;

    exp_t scoreboard[$];
    int   total;
    int   bad;

    limit_state_detector64_water #(.WIDTH(64), .DEB_N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sta         (sta),
        .clr         (clr),
        .x           (x),
        .upper_limit (upper_limit),
        .down_limit  (down_limit),
        .hi_flag     (hi_flag),
        .lo_flag     (lo_flag),
        .windup_hold (windup_hold),
        .err_sig     (err_sig),
        .hit_cnt     (hit_cnt),
        .busy        (busy),
        .done_sig    (done_sig)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every done_sig must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_sig === 1'b1) begin
                if (scoreboard.size() == 0) begin
                    check_output("unexpected_done", 16'd1, 16'd0);
                end else begin
                    e = scoreboard.pop_front();
                    check_output("hi_flag",     {15'd0, hi_flag},     {15'd0, e.hi});
                    check_output("lo_flag",     {15'd0, lo_flag},     {15'd0, e.lo});
                    check_output("windup_hold", {15'd0, windup_hold}, {15'd0, e.wh});
                    check_output("err_sig",     {15'd0, err_sig},     {15'd0, e.err});
                    check_output("hit_cnt",     hit_cnt,              e.hit);
                end
            end
        end
    end

    // One evaluation starting in the current cycle; optional clr in the UPD cycle.
    // Returns #1 into the done_sig cycle so the next call is back-to-back.
    task automatic apply_stimulus(input logic [63:0] xv, input logic [63:0] up,
                                  input logic [63:0] dn, input logic clr_upd,
                                  input logic e_hi, input logic e_lo,
                                  input logic e_wh, input logic e_err,
                                  input logic [15:0] e_hit);
        exp_t e;
        e.hi  = e_hi;
        e.lo  = e_lo;
        e.wh  = e_wh;
        e.err = e_err;
        e.hit = e_hit;
        scoreboard.push_back(e);
        x           = xv;
        upper_limit = up;
        down_limit  = dn;
        sta         = 1'b1;
        @(posedge clk); #1;
        sta         = 1'b0;
        x           = 64'hDEADBEEFDEADBEEF;
        upper_limit = Q_NAN;
        down_limit  = Q_NAN;
        check_output("busy_cmp", {15'd0, busy}, 16'd1);
        @(posedge clk); #1;
        clr = clr_upd;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        sta   = 1'b0;
        clr   = 1'b0;
        x           = '0;
        upper_limit = '0;
        down_limit  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hit",  hit_cnt, 16'd0);
        check_output("reset_outs", {10'd0, hi_flag, lo_flag, windup_hold, err_sig, busy, done_sig}, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Upper limit debounce: flag on the fourth consecutive hit.
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 1, 0, 1, 0, 16'd1);
        apply_stimulus(P_HALF, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd1);
        // Lower limit with equality, then saturation holds the flag.
        apply_stimulus(N_ONE, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd1);
        apply_stimulus(N_ONE, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd1);
        apply_stimulus(N_ONE, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd1);
        apply_stimulus(N_ONE, P_ONE, N_ONE, 1'b0, 0, 1, 1, 0, 16'd2);
        apply_stimulus(N_ONE, P_ONE, N_ONE, 1'b0, 0, 1, 1, 0, 16'd3);
        // Invalid evaluations: inverted limits, then NaN operand.
        apply_stimulus(P_ZERO, P_ONE, P_TWO, 1'b0, 0, 0, 0, 1, 16'd3);
        apply_stimulus(Q_NAN, P_ONE, N_ONE, 1'b0, 0, 0, 0, 1, 16'd3);
        // Signed zero and negative ordering on the lower bound.
        apply_stimulus(N_ZERO, P_ONE, P_ZERO, 1'b0, 0, 0, 0, 0, 16'd3);
        apply_stimulus(N_ZERO, P_ONE, P_ZERO, 1'b0, 0, 0, 0, 0, 16'd3);
        apply_stimulus(N_ZERO, P_ONE, P_ZERO, 1'b0, 0, 0, 0, 0, 16'd3);
        apply_stimulus(N_THREE, P_ONE, N_TWO, 1'b0, 0, 1, 1, 0, 16'd4);
        apply_stimulus(N_1P5, P_ONE, N_TWO, 1'b0, 0, 0, 0, 0, 16'd4);
        // x equal to both limits: both flags debounce together.
        apply_stimulus(P_ONE, P_ONE, P_ONE, 1'b0, 0, 0, 0, 0, 16'd4);
        apply_stimulus(P_ONE, P_ONE, P_ONE, 1'b0, 0, 0, 0, 0, 16'd4);
        apply_stimulus(P_ONE, P_ONE, P_ONE, 1'b0, 0, 0, 0, 0, 16'd4);
        apply_stimulus(P_ONE, P_ONE, P_ONE, 1'b0, 1, 1, 1, 0, 16'd5);

        // sta held for two cycles: the second is ignored, one done only.
        scoreboard.push_back('{hi: 1'b0, lo: 1'b0, wh: 1'b0, err: 1'b0, hit: 16'd5});
        x = P_HALF; upper_limit = P_ONE; down_limit = N_ONE;
        sta = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sta = 1'b0;
        check_output("busy_upd", {15'd0, busy}, 16'd1);
        @(posedge clk); #1;
        check_output("done_at_3", {15'd0, done_sig}, 16'd1);
        @(posedge clk); #1;
        check_output("done_gone", {15'd0, done_sig}, 16'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the UPD cycle aborts the evaluation.
        x = P_TWO;
        sta = 1'b1;
        @(posedge clk); #1;
        sta = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_output("abort_outs", {10'd0, hi_flag, lo_flag, windup_hold, err_sig, busy, done_sig}, 16'd0);
        check_output("abort_hit", hit_cnt, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // After reset: debounce restarts, then clr collides with an increment.
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 0, 0, 0, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 1, 0, 1, 0, 16'd1);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b1, 1, 0, 1, 0, 16'd0);
        apply_stimulus(P_TWO, P_ONE, N_ONE, 1'b0, 1, 0, 1, 0, 16'd1);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 20 && scoreboard.size() != 0; i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        check_output("scoreboard_left", 16'(scoreboard.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
